// File: rtl/ngp_fetch_unit.sv
// Program counter and fetch sequencer for the NandGame-plus core.
// Provides increment/jump/call/return with a register-based return stack.
module ngp_fetch_unit #(
  parameter int ADDR_W = 16,
  parameter int STACK_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  input  logic jmp,
  input  logic call,
  input  logic ret,
  input  logic [ADDR_W-1:0] target,
  input  logic err_clr,
  output logic [ADDR_W-1:0] addr,
  output logic addr_valid,
  output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
  output logic stack_full,
  output logic stack_empty,
  output logic stack_err
);

  localparam int DW = $clog2(STACK_DEPTH+1);
  localparam int IW = $clog2(STACK_DEPTH);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic [ADDR_W-1:0] inc, top;
  logic valid_q;
  logic [DW-1:0] depth_q, depth_d, dm1;
  logic err_q, err_d;
  logic push, ovf, unf, full, empty;

  assign inc = addr_q + ADDR_W'(1);
  assign full = (depth_q == DW'(STACK_DEPTH));
  assign empty = (depth_q == '0);
  assign dm1 = depth_q - DW'(1);
  // Top-of-stack read is combinational so ret completes in one cycle
  assign top = stack_q[dm1[IW-1:0]];

  always_comb begin
    addr_d = addr_q;
    depth_d = depth_q;
    push = 1'b0;
    ovf = 1'b0;
    unf = 1'b0;
    if (valid_q && !stall) begin
      priority case (1'b1)
        ret: begin
          if (empty) begin
            addr_d = inc;
            unf = 1'b1;
          end else begin
            addr_d = top;
            depth_d = dm1;
          end
        end
        call: begin
          addr_d = target;
          if (full) begin
            ovf = 1'b1;
          end else begin
            push = 1'b1;
            depth_d = depth_q + DW'(1);
          end
        end
        jmp: addr_d = target;
        default: addr_d = inc;
      endcase
    end
  end

  always_comb begin
    err_d = err_q;
    if (ovf || unf)
      err_d = 1'b1;
    else if (valid_q && err_clr)
      err_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= RESET_ADDR;
      valid_q <= 1'b0;
      depth_q <= '0;
      err_q <= 1'b0;
    end else begin
      valid_q <= 1'b1;
      addr_q <= addr_d;
      depth_q <= depth_d;
      err_q <= err_d;
    end
  end

  // Stack contents need no reset; depth alone defines what is live
  always_ff @(posedge clk) begin
    if (push)
      stack_q[depth_q[IW-1:0]] <= inc;
  end

  assign addr = addr_q;
  assign addr_valid = valid_q;
  assign depth = depth_q;
  assign stack_full = full;
  assign stack_empty = empty;
  assign stack_err = err_q;

endmodule
